nioslab2_ram_stream_loader: RTL and testbench

//  Loads a 32-bit streaming source into the 8192x32 on-chip RAM at consecutive word addresses through the RAM's second slave port.

---
 rtl/nioslab2_ram_stream_loader_pkg.sv | 16 +
 rtl/nioslab2_ram_stream_loader_addr_counter.sv | 48 ++++
 rtl/nioslab2_ram_stream_loader.sv | 165 ++++++++++++++++
 tb/tb_nioslab2_ram_stream_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nioslab2_ram_stream_loader_pkg.sv
// Shared constants and FSM state encoding for the RAM stream loader.
// Default geometry matches the 8192x32 on-chip RAM.
package nioslab2_ram_stream_loader_pkg;

  localparam int unsigned DEF_ADDR_W = 13;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 1 << DEF_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_FIN    = 2'd3
  } state_e;

endpackage

// File: rtl/nioslab2_ram_stream_loader_addr_counter.sv
// Base+offset word-address counter; the offset is reused for the write pass
// and the read-back pass, and the address wraps modulo 2**ADDR_W.
module nioslab2_ram_stream_loader_addr_counter #(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W:0]   cnt_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    base_d = base_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      base_d = base_i;
      cnt_d  = '0;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      base_q <= '0;
      cnt_q  <= '0;
    end else begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
    end
  end

  // Dropping the count MSB gives the modulo-depth wrap for free.
  assign addr_o = base_q + cnt_q[ADDR_W-1:0];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/nioslab2_ram_stream_loader.sv
// Streams words into consecutive RAM addresses, accumulating an additive
// checksum, and optionally reads the span back to confirm it.
module nioslab2_ram_stream_loader
  import nioslab2_ram_stream_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   cfg_base_i,
  input  logic [ADDR_W:0]     cfg_len_i,
  input  logic                cfg_verify_i,
  input  logic [DATA_W-1:0]   snk_data_i,
  input  logic                snk_valid_i,
  output logic                snk_ready_o,
  output logic [ADDR_W-1:0]   ram_address_o,
  output logic                ram_chipselect_o,
  output logic                ram_write_o,
  output logic [DATA_W/8-1:0] ram_byteenable_o,
  output logic [DATA_W-1:0]   ram_writedata_o,
  output logic                ram_clken_o,
  input  logic [DATA_W-1:0]   ram_readdata_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [DATA_W-1:0]   checksum_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              verify_q, verify_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [DATA_W-1:0] vsum_q, vsum_d;
  logic              rd_valid_q, rd_valid_d;
  logic              error_q, error_d;

  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic              cnt_lt_len_c, span_done_c;
  logic              load_c, clr_c, accept_c, rd_issue_c;
  logic [DATA_W-1:0] vsum_next_c;

  assign cnt_lt_len_c = cnt < len_q;
  assign span_done_c  = cnt == len_q;
  assign load_c       = (state_q == ST_IDLE) && start_i;
  assign clr_c        = (state_q == ST_WRITE) && span_done_c;
  assign accept_c     = (state_q == ST_WRITE) && snk_valid_i && cnt_lt_len_c;
  assign rd_issue_c   = (state_q == ST_VERIFY) && cnt_lt_len_c;
  assign vsum_next_c  = vsum_q + (rd_valid_q ? ram_readdata_i : '0);

  nioslab2_ram_stream_loader_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (load_c),
    .base_i  (cfg_base_i),
    .clr_i   (clr_c),
    .inc_i   (accept_c || rd_issue_c),
    .cnt_o   (cnt),
    .addr_o  (addr)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A pass ends one cycle after its count reaches len (immediately for len=0).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_WRITE;
      ST_WRITE:  if (span_done_c) state_d = (verify_q && (len_q != '0)) ? ST_VERIFY : ST_FIN;
      ST_VERIFY: if (span_done_c) state_d = ST_FIN;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    snk_ready_o      = 1'b0;
    ram_chipselect_o = 1'b0;
    ram_write_o      = 1'b0;
    ram_writedata_o  = '0;
    busy_o           = 1'b0;
    done_o           = 1'b0;
    unique case (state_q)
      ST_WRITE: begin
        busy_o      = 1'b1;
        snk_ready_o = cnt_lt_len_c;
        if (accept_c) begin
          ram_chipselect_o = 1'b1;
          ram_write_o      = 1'b1;
          ram_writedata_o  = snk_data_i;
        end
      end
      ST_VERIFY: begin
        busy_o           = 1'b1;
        ram_chipselect_o = rd_issue_c;
      end
      ST_FIN:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Read data of the read issued last cycle is folded in this cycle.
  always_comb begin
    len_d      = len_q;
    verify_d   = verify_q;
    checksum_d = checksum_q;
    vsum_d     = vsum_q;
    rd_valid_d = 1'b0;
    error_d    = error_q;
    if (load_c) begin
      len_d      = cfg_len_i;
      verify_d   = cfg_verify_i;
      checksum_d = '0;
      vsum_d     = '0;
      error_d    = 1'b0;
    end
    if (accept_c) begin
      checksum_d = checksum_q + snk_data_i;
    end
    if (state_q == ST_VERIFY) begin
      vsum_d     = vsum_next_c;
      rd_valid_d = rd_issue_c;
      if (span_done_c) begin
        error_d = vsum_next_c != checksum_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      len_q      <= '0;
      verify_q   <= 1'b0;
      checksum_q <= '0;
      vsum_q     <= '0;
      rd_valid_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      len_q      <= len_d;
      verify_q   <= verify_d;
      checksum_q <= checksum_d;
      vsum_q     <= vsum_d;
      rd_valid_q <= rd_valid_d;
      error_q    <= error_d;
    end
  end

  assign ram_address_o    = addr;
  assign ram_byteenable_o = '1;
  assign ram_clken_o      = 1'b1;
  assign error_o          = error_q;
  assign checksum_o       = checksum_q;

endmodule

// File: tb/tb_nioslab2_ram_stream_loader.sv
// Bench for the RAM stream loader: behavioural RAM with optional read
// corruption, table-driven and randomized loads checked against a span model.
module tb_nioslab2_ram_stream_loader;
  import nioslab2_ram_stream_loader_pkg::*;

  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
  localparam int M_CONT = 0, M_TOGGLE = 1, M_RAND = 2;

  logic          clk = 1'b0;
  logic          reset, start, cfg_verify, snk_valid, snk_ready;
  logic [AW-1:0] cfg_base, ram_address;
  logic [AW:0]   cfg_len;
  logic [DW-1:0] snk_data, ram_writedata, ram_readdata, checksum;
  logic          ram_chipselect, ram_write, ram_clken, busy, done, error;
  logic [DW/8-1:0] ram_byteenable;

  always #5 clk = ~clk;

  nioslab2_ram_stream_loader dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .start_i          (start),
    .cfg_base_i       (cfg_base),
    .cfg_len_i        (cfg_len),
    .cfg_verify_i     (cfg_verify),
    .snk_data_i       (snk_data),
    .snk_valid_i      (snk_valid),
    .snk_ready_o      (snk_ready),
    .ram_address_o    (ram_address),
    .ram_chipselect_o (ram_chipselect),
    .ram_write_o      (ram_write),
    .ram_byteenable_o (ram_byteenable),
    .ram_writedata_o  (ram_writedata),
    .ram_clken_o      (ram_clken),
    .ram_readdata_i   (ram_readdata),
    .busy_o           (busy),
    .done_o           (done),
    .error_o          (error),
    .checksum_o       (checksum)
  );

  // RAM: registered address, unregistered q; optional single-word read corruption
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_addr_q = '0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) mem[ram_address] <= ram_writedata;
      else           rd_addr_q <= ram_address;
    end
  end
  assign ram_readdata = mem[rd_addr_q] ^ ((corrupt_en && rd_addr_q == corrupt_addr) ? 32'h1 : 32'h0);

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] words[$];
  longint prev_cs  = 0;
  bit     prev_err = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One load operation; words[] holds the stream, expectations come from the caller.
  task automatic run_op(input int base, input int len, input bit verify, input int mode,
                        input int corrupt_off, input bit restart_mid,
                        input longint exp_cs, input bit exp_err, input int exp_lat);
    int acc = 0, bad = 0, lat = -1, budget;
    bit seen_done = 1'b0;
    budget = 4 * len + 100;
    corrupt_en   = corrupt_off >= 0;
    corrupt_addr = AW'((base + (corrupt_off < 0 ? 0 : corrupt_off)) % DEPTH);
    @(posedge clk); #1;
    start = 1'b1; cfg_base = AW'(base); cfg_len = (AW+1)'(len); cfg_verify = verify;
    snk_valid = 1'b1; snk_data = $urandom;
    #3;
    check("idle_busy", busy, 0);
    check("idle_ready", snk_ready, 0);
    check("held_checksum", checksum, prev_cs);
    check("held_error", error, prev_err);
    for (int cyc = 1; cyc <= budget && !seen_done; cyc++) begin
      @(posedge clk); #1;
      start = restart_mid && cyc == 2;
      if (start) begin
        cfg_len  = (AW+1)'(len + 3);
        cfg_base = AW'(base + 7);
      end
      case (mode)
        M_CONT:   snk_valid = 1'b1;
        M_TOGGLE: snk_valid = (cyc % 2) == 1;
        default:  snk_valid = $urandom_range(1, 0) == 1;
      endcase
      snk_data = (acc < len) ? words[acc] : $urandom;
      #3;
      if (cyc == 1) check("err_cleared", error, 0);
      if (snk_valid && snk_ready) begin
        if (acc >= len || !ram_write || !ram_chipselect ||
            ram_address != AW'((base + acc) % DEPTH) || ram_writedata != words[acc]) begin
          if (bad == 0) $display("  write %0d at addr %0d data %h", acc, ram_address, ram_writedata);
          bad++;
        end
        acc++;
      end else if (ram_write) begin
        bad++;
      end
      if (done) begin
        seen_done = 1'b1;
        lat = cyc;
        check("done_busy_low", busy, 0);
      end else if (!busy) begin
        bad++;
      end
    end
    check("done_seen", seen_done, 1);
    check("write_count", acc, len);
    check("bad_cycles", bad, 0);
    check("checksum", checksum, exp_cs);
    check("error", error, exp_err);
    if (exp_lat >= 0) check("latency", lat, exp_lat);
    prev_cs  = exp_cs;
    prev_err = exp_err;
    @(posedge clk); #1; start = 1'b0; snk_valid = 1'b0;
  endtask

  typedef struct {
    int     base;
    int     len;
    bit     verify;
    int     mode;
    int     corrupt_off;
    bit     restart;
    longint exp_cs;
    bit     exp_err;
    int     exp_lat;
  } vec_t;

  vec_t tab[7];

  initial begin
    longint cs_m;
    reset = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_verify = 1'b0;
    snk_valid = 1'b0; snk_data = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    tab[0] = '{0,    4,    1'b0, M_CONT,   -1, 1'b0, 10,       1'b0, 6};
    tab[1] = '{8190, 4,    1'b0, M_CONT,   -1, 1'b0, 10,       1'b0, 6};
    tab[2] = '{5,    0,    1'b1, M_CONT,   -1, 1'b0, 0,        1'b0, 2};
    tab[3] = '{20,   3,    1'b1, M_CONT,    1, 1'b0, 6,        1'b1, 9};
    tab[4] = '{40,   4,    1'b0, M_TOGGLE, -1, 1'b1, 10,       1'b0, 9};
    tab[5] = '{3,    8192, 1'b1, M_CONT,   -1, 1'b0, 33558528, 1'b0, 16387};
    tab[6] = '{100,  1,    1'b1, M_CONT,   -1, 1'b0, 1,        1'b0, 5};

    repeat (3) @(posedge clk);
    #1; reset = 1'b0; snk_valid = 1'b1;
    #3;
    check("rst_ready", snk_ready, 0);
    check("rst_cs", ram_chipselect, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_checksum", checksum, 0);
    check("rst_address", ram_address, 0);
    check("byteenable", ram_byteenable, 15);

    foreach (tab[k]) begin
      words.delete();
      for (int i = 0; i < tab[k].len; i++) words.push_back(DW'(i + 1));
      run_op(tab[k].base, tab[k].len, tab[k].verify, tab[k].mode, tab[k].corrupt_off,
             tab[k].restart, tab[k].exp_cs, tab[k].exp_err, tab[k].exp_lat);
    end

    // Randomized loads against the span model: sum of words, error iff a verified span saw a corrupted word
    for (int r = 0; r < 25; r++) begin
      int base, len, mode, coff, lat;
      bit ver;
      base = int'($urandom_range(DEPTH - 1, 0));
      len  = int'($urandom_range(32, 0));
      ver  = $urandom_range(1, 0) == 1;
      mode = int'($urandom_range(2, 0));
      coff = (len > 0 && $urandom_range(3, 0) == 0) ? int'($urandom_range(len - 1, 0)) : -1;
      words.delete();
      cs_m = 0;
      for (int i = 0; i < len; i++) begin
        words.push_back($urandom);
        cs_m = (cs_m + longint'(words[i])) % (64'd1 << DW);
      end
      if (mode != M_CONT) lat = -1;
      else if (ver && len > 0) lat = 1 + len + (len + 1) + 1;
      else lat = 1 + len + 1;
      run_op(base, len, ver, mode, coff, 1'b0, cs_m, ver && len > 0 && coff >= 0, lat);
    end

    // Reset in the middle of a 5-word load, after two words
    corrupt_en = 1'b0;
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back($urandom);
    @(posedge clk); #1;
    start = 1'b1; cfg_base = AW'(100); cfg_len = (AW+1)'(5); cfg_verify = 1'b0; snk_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      snk_valid = c <= 2;
      snk_data = words[c - 1];
      reset = c == 3;
      #3;
      if (c == 3) check("pre_reset_checksum", checksum, DW'(words[0] + words[1]));
    end
    @(posedge clk); #1;
    reset = 1'b0; snk_valid = 1'b1; snk_data = words[2];
    #3;
    check("mid_rst_ready", snk_ready, 0);
    check("mid_rst_cs", ram_chipselect, 0);
    check("mid_rst_write", ram_write, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_checksum", checksum, 0);
    check("mid_rst_address", ram_address, 0);
    begin
      int dones = 0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #4;
        if (done || busy) dones++;
      end
      check("no_done_after_reset", dones, 0);
    end
    check("mem_partial_word0", mem[100], words[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
